// File: rtl/fpu_cmp_pkg.sv
// Shared types and default widths for the floating-point compare unit.
// Provides the operation encoding, the per-result flag struct carried
// down the pipeline, and the default IEEE-754 single-precision geometry.
package fpu_cmp_pkg;

    localparam int unsigned DEF_EXP_W   = 8;
    localparam int unsigned DEF_MAN_W   = 23;
    localparam int unsigned DEF_TAG_W   = 5;
    localparam int unsigned DEF_LATENCY = 2;

    typedef enum logic [1:0] {
        OP_FEQ = 2'b00,
        OP_FLT = 2'b01,
        OP_FLE = 2'b10,
        OP_RSV = 2'b11
    } cmp_op_e;

    // Compare outcome; the pipeline pairs it with the request tag.
    typedef struct packed {
        logic y;
        logic nv;
    } cmp_res_t;

endpackage

// File: rtl/fcmp_core.sv
// Combinational IEEE-754 compare: classifies both operands and evaluates
// FEQ / FLT / FLE with the invalid-operation flag.
// Ports:
//   op    - requested operation (cmp_op_e)
//   x1    - operand 1, {sign, exponent, mantissa}
//   x2    - operand 2
//   y_c   - compare result
//   nv_c  - invalid-operation flag
module fcmp_core
    import fpu_cmp_pkg::*;
#(
    parameter  int unsigned EXP_W = DEF_EXP_W,
    parameter  int unsigned MAN_W = DEF_MAN_W,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  cmp_op_e        op,
    input  logic [W-1:0]   x1,
    input  logic [W-1:0]   x2,
    output logic           y_c,
    output logic           nv_c
);

    logic             s1, s2;
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] m1, m2;
    logic [W-2:0]     mag1, mag2;
    logic             nan1, nan2, snan1, snan2, zero1, zero2, any_nan;
    logic             lt, eq;

    // Field split and classification.
    assign s1    = x1[W-1];
    assign s2    = x2[W-1];
    assign e1    = x1[W-2 -: EXP_W];
    assign e2    = x2[W-2 -: EXP_W];
    assign m1    = x1[MAN_W-1:0];
    assign m2    = x2[MAN_W-1:0];
    assign mag1  = x1[W-2:0];
    assign mag2  = x2[W-2:0];
    assign nan1  = (&e1) && (|m1);
    assign nan2  = (&e2) && (|m2);
    assign snan1 = nan1 && !m1[MAN_W-1];
    assign snan2 = nan2 && !m2[MAN_W-1];
    assign zero1 = ~|mag1;
    assign zero2 = ~|mag2;
    assign any_nan = nan1 || nan2;

    // Sign-magnitude ordering; {exp,man} is monotone in magnitude, so
    // infinities and subnormals fall out of a plain unsigned compare.
    always_comb begin
        lt = 1'b0;
        eq = 1'b0;
        if (zero1 && zero2) begin
            eq = 1'b1;
        end else if (s1 != s2) begin
            lt = s1;
        end else if (!s1) begin
            lt = mag1 < mag2;
            eq = mag1 == mag2;
        end else begin
            lt = mag1 > mag2;
            eq = mag1 == mag2;
        end
    end

    // Quiet compare for FEQ, signalling compare for FLT/FLE.
    always_comb begin
        y_c  = 1'b0;
        nv_c = 1'b0;
        case (op)
            OP_FEQ: begin
                y_c  = !any_nan && eq;
                nv_c = snan1 || snan2;
            end
            OP_FLT: begin
                y_c  = !any_nan && lt;
                nv_c = any_nan;
            end
            OP_FLE: begin
                y_c  = !any_nan && (lt || eq);
                nv_c = any_nan;
            end
            default: begin
                nv_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fcmp_pipe.sv
// Elastic, in-order pipelined floating-point compare with tag pass-through.
// The compare is evaluated on the accepted operands; {y, nv, tag} then
// moves through LATENCY stages (legal 1..4). Bubbles collapse, so up to
// LATENCY results are held under back-pressure.
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   in_valid/in_ready    - request handshake
//   in_op, in_x1, in_x2  - operation and operands
//   in_tag               - opaque request tag
//   out_valid/out_ready  - result handshake
//   out_y, out_nv        - compare result and invalid flag
//   out_tag              - tag of the returned result
module fcmp_pipe
    import fpu_cmp_pkg::*;
#(
    parameter  int unsigned EXP_W   = DEF_EXP_W,
    parameter  int unsigned MAN_W   = DEF_MAN_W,
    parameter  int unsigned LATENCY = DEF_LATENCY,
    parameter  int unsigned TAG_W   = DEF_TAG_W,
    localparam int unsigned W       = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [W-1:0]     in_x1,
    input  logic [W-1:0]     in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic             out_nv,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        cmp_res_t         res;
        logic [TAG_W-1:0] tag;
    } stage_t;

    logic               core_y_c, core_nv_c;
    logic               accept_c;
    logic               all_full_c;
    logic [LATENCY-1:0] ld_c;
    logic [LATENCY-1:0] vld_q;
    stage_t             pay_q [LATENCY];

    fcmp_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_core (
        .op   (cmp_op_e'(in_op)),
        .x1   (in_x1),
        .x2   (in_x2),
        .y_c  (core_y_c),
        .nv_c (core_nv_c)
    );

    // Stage k may load unless it and every stage after it are full while
    // the consumer stalls; computed per stage to avoid a ripple loop.
    always_comb begin
        ld_c       = '0;
        all_full_c = 1'b0;
        for (int unsigned k = 0; k < LATENCY; k++) begin
            all_full_c = 1'b1;
            for (int unsigned j = k; j < LATENCY; j++) begin
                all_full_c = all_full_c & vld_q[j];
            end
            ld_c[k] = out_ready || !all_full_c;
        end
    end

    assign in_ready = ld_c[0];
    assign accept_c = in_valid && ld_c[0];

    // Stage registers; payload only moves with a valid entry so held
    // outputs stay stable under back-pressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < LATENCY; k++) begin
                pay_q[k] <= '0;
            end
        end else begin
            if (ld_c[0]) begin
                vld_q[0] <= accept_c;
                if (accept_c) begin
                    pay_q[0].res.y  <= core_y_c;
                    pay_q[0].res.nv <= core_nv_c;
                    pay_q[0].tag    <= in_tag;
                end
            end
            for (int unsigned k = 1; k < LATENCY; k++) begin
                if (ld_c[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        pay_q[k] <= pay_q[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_y     = pay_q[LATENCY-1].res.y;
    assign out_nv    = pay_q[LATENCY-1].res.nv;
    assign out_tag   = pay_q[LATENCY-1].tag;

endmodule
